instruction_line_fill: RTL and testbench
========================================

INSTRUCTION_LINE_FILL -- requirements
Module: instruction_line_fill

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: byte-address width; word addresses are ADDRESS_WIDTH-2 bits.
REQ-002 SHALL have parameter L2_BUS_WIDTH, default 512: cache line width in bits.
REQ-003 SHALL have parameter MEM_DATA_WIDTH, default 32: memory beat width; BEATS = L2_BUS_WIDTH/MEM_DATA_WIDTH (16 by default).
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ADDRESS_TO_L2_VALID_INS  input  1  cache miss request valid.
REQ-007 SHALL have port ADDRESS_TO_L2_READY_INS  output  1  adapter can accept a miss address.
REQ-008 SHALL have port ADDRESS_TO_L2_INS  input  ADDRESS_WIDTH-2  missing word address.
REQ-009 SHALL have port DATA_FROM_L2_VALID_INS  output  1  assembled line valid.
REQ-010 SHALL have port DATA_FROM_L2_READY_INS  input  1  cache accepts the line.
REQ-011 SHALL have port DATA_FROM_L2_INS  output  L2_BUS_WIDTH  assembled line.
REQ-012 SHALL have port MEM_REQ_VALID  output  1  memory read request valid.
REQ-013 SHALL have port MEM_REQ_READY  input  1  memory accepts the request.
REQ-014 SHALL have port MEM_REQ_ADDR  output  ADDRESS_WIDTH-2  requested word address.
REQ-015 SHALL have port MEM_RESP_VALID  input  1  response beat valid; in request order; no backpressure.
REQ-016 SHALL have port MEM_RESP_DATA  input  MEM_DATA_WIDTH  response word.

Function
REQ-017 SHALL implement states IDLE, FETCH and DELIVER.
REQ-018 IDLE SHALL drive ADDRESS_TO_L2_READY_INS=1; it SHALL be 0 in FETCH and DELIVER.
REQ-019 An address handshake (valid and ready high at an edge) SHALL latch the line base = ADDRESS_TO_L2_INS with its low log2(BEATS) bits cleared, clear both counters, and enter FETCH.
REQ-020 In FETCH, MEM_REQ_VALID SHALL be 1 while the issue counter is below BEATS, with MEM_REQ_ADDR = base + issue counter.
REQ-021 Each edge with MEM_REQ_VALID and MEM_REQ_READY both high SHALL increment the issue counter; MEM_REQ_VALID and MEM_REQ_ADDR SHALL stay stable until accepted.
REQ-022 Each edge with MEM_RESP_VALID high in FETCH SHALL write MEM_RESP_DATA into line bits [MEM_DATA_WIDTH*k +: MEM_DATA_WIDTH], where k is the receive counter, and SHALL increment k.
REQ-023 A request acceptance and a response on the same edge SHALL both take effect.
REQ-024 The response on which k = BEATS-1 SHALL move the state to DELIVER on that edge.
REQ-025 MEM_RESP_VALID in IDLE or DELIVER, or beyond BEATS responses, SHALL be ignored.
REQ-026 DELIVER SHALL drive DATA_FROM_L2_VALID_INS=1 with DATA_FROM_L2_INS held stable.
REQ-027 DATA_FROM_L2_READY_INS high in DELIVER SHALL return the state to IDLE on that edge.
REQ-028 Back-to-back misses SHALL cost at least one IDLE cycle between lines.
REQ-029 Minimum latency: with MEM_REQ_READY tied to 1 and each response one cycle after acceptance, DATA_FROM_L2_VALID_INS SHALL rise 17 edges after the address handshake edge.
REQ-030 Counters SHALL be log2(BEATS)+1 bits wide; base + issue counter SHALL wrap modulo 2^(ADDRESS_WIDTH-2).

Reset
REQ-031 RST high at an edge SHALL force IDLE, zero both counters, zero the line register and base, and drive MEM_REQ_VALID=0, DATA_FROM_L2_VALID_INS=0 and ADDRESS_TO_L2_READY_INS=1 from the next cycle.
REQ-032 RST asserted mid-FETCH or mid-DELIVER SHALL abandon the line; later responses SHALL be ignored per REQ-025.

Verification
REQ-033 The bench SHALL cover: miss address 0x00000013, MEM_REQ_READY=1, 1-cycle memory returning word address as data -> MEM_REQ_ADDR 0x10..0x1F in order, line word k = 0x10+k, valid at edge +17.
REQ-034 The bench SHALL cover: MEM_REQ_READY toggling 1/0 each cycle -> address held during stalls, 16 requests issued, no duplicates, correct line.
REQ-035 The bench SHALL cover: DATA_FROM_L2_READY_INS held low 5 cycles in DELIVER -> valid and data stable for 5 cycles, ADDRESS_TO_L2_READY_INS=0, then IDLE.
REQ-036 The bench SHALL cover: miss at word address 0x3FFFFFFF -> addresses 0x3FFFFFF0..0x3FFFFFFF, no overflow into other bits.
REQ-037 The bench SHALL cover: RST after 7 responses, then a new miss at 0x40 -> stale responses ignored, new line holds only words from 0x40..0x4F.
REQ-038 The bench SHALL cover: response arriving on the same edge as a request acceptance -> both counters advance and the line is correct.

Source files
------------

// File: rtl/instruction_line_fill.sv
// instruction_line_fill: gathers BEATS memory words into one cache line per instruction-cache miss
// Ports: CLK/RST (sync, active-high); ADDRESS_TO_L2_* miss request in; DATA_FROM_L2_* assembled line out;
//        MEM_REQ_* word-read requests out; MEM_RESP_* in-order response beats in (no backpressure).
module instruction_line_fill #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int L2_BUS_WIDTH   = 512,
    parameter int MEM_DATA_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ADDRESS_TO_L2_VALID_INS,
    output logic                      ADDRESS_TO_L2_READY_INS,
    input  logic [ADDRESS_WIDTH-3:0]  ADDRESS_TO_L2_INS,
    output logic                      DATA_FROM_L2_VALID_INS,
    input  logic                      DATA_FROM_L2_READY_INS,
    output logic [L2_BUS_WIDTH-1:0]   DATA_FROM_L2_INS,
    output logic                      MEM_REQ_VALID,
    input  logic                      MEM_REQ_READY,
    output logic [ADDRESS_WIDTH-3:0]  MEM_REQ_ADDR,
    input  logic                      MEM_RESP_VALID,
    input  logic [MEM_DATA_WIDTH-1:0] MEM_RESP_DATA
);
    localparam int AW    = ADDRESS_WIDTH - 2;
    localparam int BEATS = L2_BUS_WIDTH / MEM_DATA_WIDTH;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);
    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;
    state_t state, state_n;
    logic [AW-1:0] base;
    logic [CW-1:0] issue_cnt, recv_cnt;
    logic [BEATS-1:0][MEM_DATA_WIDTH-1:0] line;
    logic addr_hs, resp_take;
    assign addr_hs   = state == IDLE && ADDRESS_TO_L2_VALID_INS;
    assign resp_take = state == FETCH && MEM_RESP_VALID && recv_cnt < BEATS_C;
    assign ADDRESS_TO_L2_READY_INS = state == IDLE;
    assign DATA_FROM_L2_VALID_INS  = state == DELIVER;
    assign DATA_FROM_L2_INS        = line;
    assign MEM_REQ_VALID           = state == FETCH && issue_cnt < BEATS_C;
    assign MEM_REQ_ADDR            = base + AW'(issue_cnt);
    always_comb begin
        state_n = addr_hs ? FETCH :
                  (resp_take && recv_cnt == LAST_C) ? DELIVER :
                  (state == DELIVER && DATA_FROM_L2_READY_INS) ? IDLE : state;
    end
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            line      <= '0;
        end else begin
            if (addr_hs) begin
                base      <= ADDRESS_TO_L2_INS & ~AW'(BEATS - 1);
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (MEM_REQ_VALID && MEM_REQ_READY) issue_cnt <= issue_cnt + CW'(1);
            if (resp_take) begin
                line[recv_cnt[CW-2:0]] <= MEM_RESP_DATA;
                recv_cnt               <= recv_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_instruction_line_fill.sv
// tb_instruction_line_fill: scoreboard bench for instruction_line_fill with a one-cycle memory model
module tb_instruction_line_fill;
    logic         clk = 0;
    logic         rst = 1;
    logic         addr_valid = 0;
    logic         addr_ready;
    logic [29:0]  addr_in = '0;
    logic         dlv_valid;
    logic         dlv_ready = 0;
    logic [511:0] dlv_data;
    logic         req_valid;
    logic         req_ready = 0;
    logic [29:0]  req_addr;
    logic         resp_valid = 0;
    logic [31:0]  resp_data = '0;
    int checks = 0;
    int errors = 0;
    logic [29:0]  exp_addr[$];
    logic [511:0] exp_line[$];
    logic [31:0]  pend[$];

    instruction_line_fill dut (
        .CLK(clk), .RST(rst),
        .ADDRESS_TO_L2_VALID_INS(addr_valid), .ADDRESS_TO_L2_READY_INS(addr_ready),
        .ADDRESS_TO_L2_INS(addr_in),
        .DATA_FROM_L2_VALID_INS(dlv_valid), .DATA_FROM_L2_READY_INS(dlv_ready),
        .DATA_FROM_L2_INS(dlv_data),
        .MEM_REQ_VALID(req_valid), .MEM_REQ_READY(req_ready), .MEM_REQ_ADDR(req_addr),
        .MEM_RESP_VALID(resp_valid), .MEM_RESP_DATA(resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr_rdy"}, addr_ready, 1);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_dlv_valid"}, dlv_valid, 0);
    endtask

    task automatic run_line(input logic [29:0] a, input bit tog, input int stall, input int abort_after);
        logic [29:0]  b = a & ~30'hF;
        logic [511:0] l = '0;
        logic [511:0] snap;
        logic [29:0]  last_addr = '0;
        bit last_stalled = 0;
        bit tg = 1;
        bit aborted = 0;
        int edges = 0;
        int reqs = 0;
        int resp_n = 0;
        for (int k = 0; k < 16; k++) begin
            exp_addr.push_back(b + 30'(k));
            l[32*k +: 32] = 32'(b + 30'(k));
        end
        exp_line.push_back(l);
        check("hs_addr_rdy", addr_ready, 1);
        addr_valid = 1;
        addr_in = a;
        @(negedge clk);
        addr_valid = 0;
        check("fetch_addr_rdy", addr_ready, 0);
        while (edges < 300) begin
            if (dlv_valid) break;
            if (abort_after > 0 && resp_n == abort_after) begin
                aborted = 1;
                break;
            end
            resp_valid = 0;
            if (pend.size() > 0) begin
                resp_valid = 1;
                resp_data = pend.pop_front();
                resp_n++;
            end
            if (req_valid && last_stalled) check("req_hold", req_addr, last_addr);
            req_ready = tog ? tg : 1'b1;
            tg = ~tg;
            if (req_valid && req_ready) begin
                if (exp_addr.size() > 0) check("req_addr", req_addr, exp_addr.pop_front());
                else check("req_extra", req_addr, 'x);
                pend.push_back(32'(req_addr));
                reqs++;
            end
            last_stalled = req_valid && !req_ready;
            last_addr = req_addr;
            @(negedge clk);
            edges++;
        end
        resp_valid = 0;
        req_ready = 0;
        if (aborted) begin
            rst = 1;
            resp_valid = 1;
            resp_data = 32'hDEAD_BEEF;
            @(negedge clk);
            rst = 0;
            check_idle("abort");
            check("abort_data", dlv_data, '0);
            for (int i = 0; i < 3; i++) begin
                resp_data = 32'hBAD0_0000 + 32'(i);
                @(negedge clk);
            end
            resp_valid = 0;
            check_idle("stale");
            check("stale_data", dlv_data, '0);
            exp_addr.delete();
            exp_line.delete();
            pend.delete();
            return;
        end
        check("dlv_timeout", edges < 300, 1);
        if (!tog) check("latency", edges, 17);
        check("req_count", reqs, 16);
        snap = dlv_data;
        for (int i = 0; i < stall; i++) begin
            resp_valid = 1;
            resp_data = 32'hCAFE_0000 + 32'(i);
            addr_valid = 1;
            addr_in = 30'h155;
            dlv_ready = 0;
            @(negedge clk);
            check("stall_valid", dlv_valid, 1);
            check("stall_data", dlv_data, snap);
            check("stall_addr_rdy", addr_ready, 0);
            check("stall_req_valid", req_valid, 0);
        end
        resp_valid = 0;
        addr_valid = 0;
        dlv_ready = 1;
        check("line", dlv_data, exp_line.pop_front());
        @(negedge clk);
        dlv_ready = 0;
        check_idle("post");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        check_idle("reset");
        check("reset_data", dlv_data, '0);
        check("reset_req_addr", req_addr, '0);
        run_line(30'h13, 0, 0, 0);
        run_line(30'h25, 1, 0, 0);
        run_line(30'h77, 0, 5, 0);
        run_line(30'h3FFF_FFFF, 0, 1, 0);
        run_line(30'h123, 1, 0, 7);
        run_line(30'h40, 0, 0, 0);
        check("queues_empty", exp_addr.size() + exp_line.size() + pend.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
